// File: rtl/debug_run_controller_pkg.sv
// Shared core definitions: instruction/address types, halt cause codes and the
// EBREAK encoding used by the debug run controller (see DEBUG_BREAKPOINT_EN in the top).
package CoreDefs;

    typedef logic [31:0] InstAddr;
    typedef logic [31:0] Inst;

    typedef enum logic [2:0] {
        HALT_NONE       = 3'd0,
        HALT_REQUEST    = 3'd1,
        HALT_BREAKPOINT = 3'd2,
        HALT_EBREAK     = 3'd3,
        HALT_STEP       = 3'd4
    } HaltCause;

    localparam Inst EBREAK_INST = 32'h0010_0073;

    // Fixed precedence when several halt sources fire in the same cycle.
    function automatic HaltCause resolve_cause(input logic ebreak,
                                               input logic bp_hit,
                                               input logic halt_req);
        HaltCause c;
        c = HALT_NONE;
        if (ebreak)        c = HALT_EBREAK;
        else if (bp_hit)   c = HALT_BREAKPOINT;
        else if (halt_req) c = HALT_REQUEST;
        return c;
    endfunction

endpackage

// File: rtl/debug_run_controller_bp.sv
// Breakpoint address comparator; only present when DEBUG_BREAKPOINT_EN is defined.
`ifdef DEBUG_BREAKPOINT_EN
module debug_breakpoint_unit
    import CoreDefs::*;
(
    input  logic    i_isValid,
    input  InstAddr i_pc,
    input  InstAddr i_bpAddr,
    input  logic    i_bpEnable,
    output logic    o_hit
);

    assign o_hit = i_isValid && i_bpEnable && (i_pc == i_bpAddr);

endmodule
`endif

// File: rtl/debug_run_controller.sv
// Debug run/halt/step controller with retire counter. Breakpoint halts exist only
// when DEBUG_BREAKPOINT_EN is defined; otherwise the breakpoint ports are ignored.
module debug_run_controller
    import CoreDefs::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_haltReq,
    input  logic        i_resumeReq,
    input  logic        i_stepReq,
    input  logic        i_isValid,
    input  InstAddr     i_pc,
    input  Inst         i_inst,
    input  logic        i_pipeEmpty,
    input  InstAddr     i_bpAddr,
    input  logic        i_bpEnable,
    output logic        o_stall,
    output logic        o_halted,
    output logic [2:0]  o_haltCause,
    output logic        o_ack,
    output logic [31:0] o_retireCount,
    output logic [1:0]  o_debugState
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    logic [1:0]  state_q, state_d;
    HaltCause    cause_q, cause_d;
    logic        ack_q, ack_d;
    logic        stall_q, stall_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;

    logic        bp_hit;
    logic        is_ebreak;

`ifdef DEBUG_BREAKPOINT_EN
    debug_breakpoint_unit u_bp (
        .i_isValid  (i_isValid),
        .i_pc       (i_pc),
        .i_bpAddr   (i_bpAddr),
        .i_bpEnable (i_bpEnable),
        .o_hit      (bp_hit)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{i_pc, i_bpAddr, i_bpEnable};
    assign bp_hit    = 1'b0;
`endif

    assign is_ebreak = i_isValid && (i_inst == EBREAK_INST);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                // The host request is acknowledged even when a higher-priority cause wins.
                if (is_ebreak || bp_hit || i_haltReq) begin
                    state_d = ST_DRAIN;
                    cause_d = resolve_cause(is_ebreak, bp_hit, i_haltReq);
                    ack_d   = i_haltReq;
                end
            end
            ST_DRAIN: begin
                if (i_pipeEmpty) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (i_resumeReq) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b1;
                end else if (i_stepReq) begin
                    state_d = ST_STEP;
                    ack_d   = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_DRAIN;
                cause_d = HALT_STEP;
            end
            default: state_d = ST_RUN;
        endcase
        // Status outputs are registered from the next state so they line up with it.
        stall_d  = (state_d == ST_DRAIN) || (state_d == ST_HALTED);
        halted_d = (state_d == ST_HALTED);
        count_d  = count_q + 32'(i_isValid);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_RUN;
            cause_q  <= HALT_NONE;
            ack_q    <= 1'b0;
            stall_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            ack_q    <= ack_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign o_stall       = stall_q;
    assign o_halted      = halted_q;
    assign o_haltCause   = cause_q;
    assign o_ack         = ack_q;
    assign o_retireCount = count_q;
    assign o_debugState  = state_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Bench for debug_run_controller: vector table, corner sequences and random
// stimulus against a reference model. Expectations follow DEBUG_BREAKPOINT_EN.
module tb_debug_run_controller;
    import CoreDefs::*;

`ifdef DEBUG_BREAKPOINT_EN
    localparam bit         BP_ON    = 1'b1;
    localparam logic [2:0] BP_CAUSE = 3'd2;
`else
    localparam bit         BP_ON    = 1'b0;
    localparam logic [2:0] BP_CAUSE = 3'd1;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EB  = 32'h0010_0073;

    typedef struct {
        logic        halt, resume, step, valid;
        logic [31:0] pc, inst;
        logic        empty;
        logic [31:0] bp_addr;
        logic        bp_en;
        logic        e_stall, e_halted;
        logic [2:0]  e_cause;
        logic        e_ack;
        logic [31:0] e_count;
    } vec_t;

    logic        clk, rst_n;
    logic        halt_req, resume_req, step_req, is_valid, pipe_empty, bp_enable;
    logic [31:0] pc, inst, bp_addr;
    logic        stall, halted, ack;
    logic [2:0]  cause;
    logic [31:0] count;
    logic [1:0]  dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [37:0] exp_q[$];
    vec_t        tbl[16];

    // Reference model: operating mode plus recorded cause and counter.
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_STEP = 3;
    int          m_mode;
    logic [2:0]  m_cause;
    logic [31:0] m_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    debug_run_controller dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_haltReq     (halt_req),
        .i_resumeReq   (resume_req),
        .i_stepReq     (step_req),
        .i_isValid     (is_valid),
        .i_pc          (pc),
        .i_inst        (inst),
        .i_pipeEmpty   (pipe_empty),
        .i_bpAddr      (bp_addr),
        .i_bpEnable    (bp_enable),
        .o_stall       (stall),
        .o_halted      (halted),
        .o_haltCause   (cause),
        .o_ack         (ack),
        .o_retireCount (count),
        .o_debugState  (dbg_state)
    );

    function automatic vec_t mk(input logic h, r, s, v, input logic [31:0] p, i,
                                input logic e, input logic [31:0] ba, input logic be,
                                input logic xs, xh, input logic [2:0] xc,
                                input logic xa, input logic [31:0] xn);
        vec_t t;
        t.halt = h; t.resume = r; t.step = s; t.valid = v; t.pc = p; t.inst = i;
        t.empty = e; t.bp_addr = ba; t.bp_en = be;
        t.e_stall = xs; t.e_halted = xh; t.e_cause = xc; t.e_ack = xa; t.e_count = xn;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic xs, xh, input logic [2:0] xc,
                             input logic xa, input logic [31:0] xn);
        check({tag, ".stall"},  32'(stall),  32'(xs));
        check({tag, ".halted"}, 32'(halted), 32'(xh));
        check({tag, ".cause"},  32'(cause),  32'(xc));
        check({tag, ".ack"},    32'(ack),    32'(xa));
        check({tag, ".count"},  count,       xn);
    endtask

    task automatic apply(input vec_t t);
        halt_req   = t.halt;
        resume_req = t.resume;
        step_req   = t.step;
        is_valid   = t.valid;
        pc         = t.pc;
        inst       = t.inst;
        pipe_empty = t.empty;
        bp_addr    = t.bp_addr;
        bp_enable  = t.bp_en;
    endtask

    task automatic set_idle();
        apply(mk(0, 0, 0, 0, 32'h0, NOP, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset off the clock edge, checks outputs immediately, releases on a negedge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_all(tag, 0, 0, 3'd0, 0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_mode  = M_RUN;
        m_cause = 3'd0;
        m_count = 32'd0;
    endtask

    task automatic model_step(input vec_t t);
        logic eb, bp, a;
        eb = t.valid && (t.inst == EB);
        bp = BP_ON && t.valid && t.bp_en && (t.pc == t.bp_addr);
        a  = 1'b0;
        if (m_mode == M_RUN) begin
            if (eb || bp || t.halt) begin
                m_cause = eb ? 3'd3 : (bp ? 3'd2 : 3'd1);
                a       = t.halt;
                m_mode  = M_DRAIN;
            end
        end else if (m_mode == M_DRAIN) begin
            if (t.empty) m_mode = M_HALTED;
        end else if (m_mode == M_HALTED) begin
            if (t.resume) begin
                m_mode = M_RUN;
                a      = 1'b1;
            end else if (t.step) begin
                m_mode = M_STEP;
                a      = 1'b1;
            end
        end else begin
            m_mode  = M_DRAIN;
            m_cause = 3'd4;
        end
        if (t.valid) m_count = m_count + 32'd1;
        exp_q.push_back({(m_mode == M_DRAIN) || (m_mode == M_HALTED),
                         m_mode == M_HALTED, m_cause, a, m_count});
    endtask

    initial begin
        logic [37:0] e;
        vec_t        rv;
        logic [31:0] addrs[3];
        addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;

        //            h  r  s  v  pc       inst empty bpaddr  bpen  stall halted cause    ack count
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    1,     0,     3'd1,    1,  0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    1,     1,     3'd1,    0,  0);
        tbl[2]  = mk(1, 0, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    1,     1,     3'd1,    0,  0);
        tbl[3]  = mk(0, 0, 1, 0, 32'h0,   NOP, 1, 32'h0,   0,    0,     0,     3'd1,    1,  0);
        tbl[4]  = mk(0, 0, 0, 1, 32'h200, NOP, 0, 32'h0,   0,    1,     0,     3'd4,    0,  1);
        tbl[5]  = mk(0, 0, 0, 1, 32'h204, NOP, 0, 32'h0,   0,    1,     0,     3'd4,    0,  2);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    1,     1,     3'd4,    0,  2);
        tbl[7]  = mk(0, 1, 1, 0, 32'h0,   NOP, 1, 32'h0,   0,    0,     0,     3'd4,    1,  2);
        tbl[8]  = mk(0, 1, 1, 0, 32'h0,   NOP, 1, 32'h0,   0,    0,     0,     3'd4,    0,  2);
        tbl[9]  = mk(1, 0, 0, 1, 32'h100, EB,  0, 32'h100, 1,    1,     0,     3'd3,    1,  3);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    1,     1,     3'd3,    0,  3);
        tbl[11] = mk(0, 1, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    0,     0,     3'd3,    1,  3);
        tbl[12] = mk(1, 0, 0, 1, 32'h100, NOP, 0, 32'h100, 1,    1,     0,     BP_CAUSE, 1, 4);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    1,     1,     BP_CAUSE, 0, 4);
        tbl[14] = mk(0, 1, 0, 0, 32'h0,   NOP, 1, 32'h0,   0,    0,     0,     BP_CAUSE, 1, 4);
        tbl[15] = mk(0, 0, 0, 1, 32'h100, NOP, 0, 32'h100, 1,    BP_ON, 0,     BP_CAUSE, 0, 5);

        rst_n = 1'b0;
        set_idle();
        #12;
        check_all("reset", 0, 0, 3'd0, 0, 32'd0);

        // Row 0 is presented together with reset release to catch the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i]);
            tick();
            check_all($sformatf("row%0d", i), tbl[i].e_stall, tbl[i].e_halted,
                      tbl[i].e_cause, tbl[i].e_ack, tbl[i].e_count);
        end

        // Asynchronous reset while draining.
        do_reset("reset2");
        set_idle();
        halt_req = 1'b1;
        tick();
        check_all("drain_enter", 1, 0, 3'd1, 1, 32'd0);
        set_idle();
        is_valid = 1'b1;
        tick();
        check_all("drain_hold", 1, 0, 3'd1, 0, 32'd1);
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_all("drain_reset", 0, 0, 3'd0, 0, 32'd0);

        // Counter wrap from all-ones.
        @(negedge clk);
        rst_n = 1'b1;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        is_valid = 1'b1;
        pc       = 32'h300;
        tick();
        check("wrap.count", count, 32'd0);
        check("wrap.stall", 32'(stall), 32'd0);
        is_valid = 1'b1;
        tick();
        check("wrap.next", count, 32'd1);

        // Randomized run against the reference model.
        do_reset("reset3");
        for (int n = 0; n < 600; n++) begin
            rv = mk(0, 0, 0, 0, 32'h0, NOP, 0, 32'h0, 0, 0, 0, 0, 0, 0);
            rv.halt    = ($urandom_range(0, 5) == 0);
            rv.resume  = ($urandom_range(0, 3) == 0);
            rv.step    = ($urandom_range(0, 3) == 0);
            rv.valid   = ($urandom_range(0, 1) == 1);
            rv.pc      = addrs[$urandom_range(0, 2)];
            rv.inst    = ($urandom_range(0, 7) == 0) ? EB : $urandom;
            rv.empty   = ($urandom_range(0, 1) == 1);
            rv.bp_addr = addrs[$urandom_range(0, 2)];
            rv.bp_en   = ($urandom_range(0, 1) == 1);
            apply(rv);
            model_step(rv);
            tick();
            e = exp_q.pop_front();
            check_all($sformatf("rand%0d", n), e[37], e[36], e[35:33], e[32], e[31:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
